// File: rtl/req_grant_arbiter_pkg.sv
// Shared types and constants for the request/grant arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   ARB_MAX_REQ      : largest supported number of requesters
//   ARB_DEFAULT_HOLD : default maximum hold time, in BUSY cycles
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_GAP
    } arb_state_e;

    localparam int ARB_MAX_REQ      = 16;
    localparam int ARB_DEFAULT_HOLD = 8;

endpackage

// File: rtl/req_grant_arbiter_rr_pick.sv
// Round-robin winner selection, purely combinational.
//   request   : per-requester request lines
//   last      : index of the previous owner (lowest priority)
//   winner    : one-hot winner, zero when nobody requests
//   winner_id : index of the winner
//   any       : at least one request is set
module rr_pick
    import arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IDW-1:0]     last,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDW-1:0]     winner_id,
    output logic               any
);

    int idx;

    // Scan from the farthest position back to last+1 so that the nearest
    // set bit after last is the one that survives.
    always_comb begin
        winner    = '0;
        winner_id = '0;
        idx       = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (request[IDW'(idx)]) begin
                winner              = '0;
                winner[IDW'(idx)]   = 1'b1;
                winner_id           = IDW'(idx);
            end
        end
    end

    assign any = |request;

endmodule

// File: rtl/req_grant_arbiter.sv
// Round-robin request/grant arbiter with bounded hold time.
//   clk         : clock, all state on posedge
//   rst_n       : asynchronous active-low reset
//   request     : per-requester request level
//   grant       : one-hot-or-zero grant, owner masked by request
//   grant_valid : OR of grant
//   grant_id    : index of the current owner (valid with grant_valid)
// Optional: define ARB_ASSERT_EN to compile in protocol assertions.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ARB_IDLE | no owner, waiting for any request
// ARB_BUSY | owner_q holds the grant while its request stays high
// ARB_GAP  | one grant-free cycle between owners, then re-arbitrate
module req_grant_arbiter
    import arb_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  MAX_HOLD = ARB_DEFAULT_HOLD,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] request,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id
);

    // A zero MAX_HOLD would give a zero-width counter; keep one bit.
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] owner_q;
    logic [IDW-1:0]     last_q;
    logic [IDW-1:0]     id_q;
    logic [HOLD_W-1:0]  hold_q;

    logic [NUM_REQ-1:0] winner;
    logic [IDW-1:0]     winner_id;
    logic               any_req;
    logic               owner_req;
    logic               others_req;
    logic               preempt;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .request   (request),
        .last      (last_q),
        .winner    (winner),
        .winner_id (winner_id),
        .any       (any_req)
    );

    assign owner_req  = |(owner_q & request);
    assign others_req = |(request & ~owner_q);
    assign preempt    = (MAX_HOLD != 0) && (hold_q == HOLD_SAT) && others_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            id_q    <= '0;
            hold_q  <= '0;
        end else begin
`ifdef ARB_ASSERT_EN
            a_onehot: assert ($onehot0(grant))
                else $error("a_onehot: grant not one-hot at %0t", $time);
            a_masked: assert ((grant & ~request) == '0)
                else $error("a_masked: grant without request at %0t", $time);
            a_id: assert (!grant_valid || grant[grant_id])
                else $error("a_id: grant_id does not match grant at %0t", $time);
            a_gap: assert (state_q != ARB_GAP || grant == '0)
                else $error("a_gap: grant during gap at %0t", $time);
            if (MAX_HOLD != 0) begin
                a_hold: assert (int'(hold_q) < MAX_HOLD)
                    else $error("a_hold: hold counter overflow at %0t", $time);
            end
`endif
            case (state_q)
                ARB_IDLE, ARB_GAP: begin
                    if (any_req) begin
                        state_q <= ARB_BUSY;
                        owner_q <= winner;
                        last_q  <= winner_id;
                        id_q    <= winner_id;
                        hold_q  <= '0;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    if (!owner_req || preempt) begin
                        state_q <= ARB_GAP;
                        owner_q <= '0;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    owner_q <= '0;
                end
            endcase
        end
    end

    // The request mask is the only combinational path to the outputs; it
    // lets grant drop in the same cycle the owner releases or reset hits.
    assign grant       = owner_q & request;
    assign grant_valid = |grant;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_req_grant_arbiter.sv
module tb_req_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] request = 4'b0000;
    logic [3:0] grant, grant0;
    logic       grant_valid, grant_valid0;
    logic [1:0] grant_id, grant_id0;

    int errors = 0;
    int checks = 0;
    bit sel_dut = 1'b0;
    bit inv_en = 1'b0;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        bit         sel;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    req_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    req_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .grant       (grant0),
        .grant_valid (grant_valid0),
        .grant_id    (grant_id0)
    );

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
        end
    endtask

    // Drive one request vector per cycle and queue the expected grant.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                        input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            request = r;
            exp_q.push_back('{g: g, id: id, sel: sel_dut, tag: tag});
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_valid", {3'b0, grant_valid}, 4'b0000);
        chk("rst_id", {2'b0, grant_id}, 4'b0000);
        chk("rst_grant0", grant0, 4'b0000);
        request = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: one expected entry per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        logic [3:0] ag;
        logic       av;
        logic [1:0] aid;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                ag  = e.sel ? grant0 : grant;
                av  = e.sel ? grant_valid0 : grant_valid;
                aid = e.sel ? grant_id0 : grant_id;
                chk({e.tag, "_grant"}, ag, e.g);
                chk({e.tag, "_valid"}, {3'b0, av}, {3'b0, |e.g});
                if (|e.g) chk({e.tag, "_id"}, {2'b0, aid}, {2'b0, e.id});
            end
        end
    end

    // Downstream rule under random traffic: grant implies request, one-hot.
    initial begin
        forever begin
            @(negedge clk);
            if (inv_en) begin
                chk("rnd_mask", grant & ~request, 4'b0000);
                chk("rnd_mask0", grant0 & ~request, 4'b0000);
                chk("rnd_onehot", {3'b0, $onehot0(grant)}, 4'b0001);
                chk("rnd_valid", {3'b0, grant_valid}, {3'b0, |grant});
            end
        end
    end

    initial begin
        do_reset();

        // single requester, release, gap, idle, then wrap-around pick
        step(4'b0000, 4'b0000, 2'd0, 2, "idle");
        step(4'b0100, 4'b0000, 2'd0, 1, "single");
        step(4'b0100, 4'b0100, 2'd2, 2, "single");
        step(4'b0000, 4'b0000, 2'd0, 3, "single_rel");
        step(4'b0001, 4'b0000, 2'd0, 1, "wrap");
        step(4'b0001, 4'b0001, 2'd0, 1, "wrap");
        step(4'b0000, 4'b0000, 2'd0, 3, "wrap_rel");

        // reset while granted: grant must vanish without a clock edge
        step(4'b0010, 4'b0000, 2'd0, 1, "mid");
        step(4'b0010, 4'b0010, 2'd1, 2, "mid");
        @(posedge clk);
        #2;
        chk("mid_pre", grant, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_valid", {3'b0, grant_valid}, 4'b0000);
        request = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // all request, each drops after two grant cycles: order 0,1,2,3,0
        step(4'b1111, 4'b0000, 2'd0, 1, "rr");
        step(4'b1111, 4'b0001, 2'd0, 2, "rr0");
        step(4'b1110, 4'b0000, 2'd0, 2, "rr_gap0");
        step(4'b1110, 4'b0010, 2'd1, 2, "rr1");
        step(4'b1100, 4'b0000, 2'd0, 2, "rr_gap1");
        step(4'b1100, 4'b0100, 2'd2, 2, "rr2");
        step(4'b1000, 4'b0000, 2'd0, 2, "rr_gap2");
        step(4'b1000, 4'b1000, 2'd3, 2, "rr3");
        step(4'b0001, 4'b0000, 2'd0, 2, "rr_gap3");
        step(4'b0001, 4'b0001, 2'd0, 1, "rr0b");
        step(4'b0000, 4'b0000, 2'd0, 3, "rr_rel");

        // preemption after 8 cycles with a competitor pending
        do_reset();
        step(4'b0011, 4'b0000, 2'd0, 1, "hold");
        step(4'b0011, 4'b0001, 2'd0, 8, "hold0");
        step(4'b0011, 4'b0000, 2'd0, 1, "hold_gap");
        step(4'b0011, 4'b0010, 2'd1, 8, "hold1");
        step(4'b0011, 4'b0000, 2'd0, 1, "hold_gap");
        step(4'b0011, 4'b0001, 2'd0, 2, "hold0b");
        step(4'b0000, 4'b0000, 2'd0, 1, "hold_rel");

        // MAX_HOLD=0: no preemption
        do_reset();
        sel_dut = 1'b1;
        step(4'b0011, 4'b0000, 2'd0, 1, "nohold");
        step(4'b0011, 4'b0001, 2'd0, 50, "nohold");
        step(4'b0000, 4'b0000, 2'd0, 1, "nohold_rel");
        sel_dut = 1'b0;
        @(negedge clk);
        #1;

        inv_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            request = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        #1;
        inv_en = 1'b0;

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_grant_arbiter.md
# req_grant_arbiter

Round-robin arbiter that turns per-requester `request` lines into one-hot `grant` lines for the request/grant checker stage directly downstream. Each grant is held while its requester keeps `request` high. A grant is forcibly released after `MAX_HOLD` cycles if others are waiting. `grant` is masked by `request`, so the downstream rule "grant implies request at every posedge" holds by construction.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `MAX_HOLD`, default 8: maximum consecutive BUSY cycles for one owner while others request. 0 disables preemption.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `request` in NUM_REQ: per-requester request, level.
- `grant` out NUM_REQ: one-hot-or-zero grant, equal to `owner_q & request`.
- `grant_valid` out 1: OR of `grant`.
- `grant_id` out $clog2(NUM_REQ): index of `owner_q`. Meaningful only when `grant_valid` is 1.

## Operation
- Registers:
  - `state_q` in {ARB_IDLE, ARB_BUSY, ARB_GAP}.
  - `owner_q`: one-hot or zero.
  - `last_q`: index of the last owner.
  - `hold_q`: counter, width $clog2(MAX_HOLD+1).
- Winner: the first set bit of `request`, scanning upward circularly from `last_q+1`.
- ARB_IDLE:
  - If any `request` is set: go to ARB_BUSY, load `owner_q` with the winner, set `last_q` to the winner index, clear `hold_q`.
  - Otherwise stay.
- ARB_BUSY:
  - If the owner's `request` is 0: go to ARB_GAP and clear `owner_q`.
  - Else if `MAX_HOLD != 0`, `hold_q == MAX_HOLD-1`, and any other `request` bit is set: go to ARB_GAP (preemption) and clear `owner_q`.
  - Else stay and increment `hold_q`, saturating at MAX_HOLD-1.
- ARB_GAP: always exactly one cycle with no grant.
  - Then go to ARB_BUSY with a new winner if any `request` is set, else to ARB_IDLE.
- A drop of the owner's request and new requests arriving at the same edge still pass through ARB_GAP.
- A preempted owner still requesting competes normally in ARB_GAP. It has lowest priority because `last_q` points at it.
- Reset values, asserted asynchronously:
  - `state_q` = ARB_IDLE, `owner_q` = 0, `last_q` = NUM_REQ-1 (index 0 wins first), `hold_q` = 0.
  - `grant` = 0, `grant_valid` = 0, `grant_id` = 0.
- Reset mid-grant removes `grant` immediately, without waiting for a clock.

## Timing
- Grant latency: a request sampled at posedge N in ARB_IDLE gives `grant` high just after N. The downstream checker first sees it at posedge N+1.
- Release: `grant` falls combinationally in the same cycle the owner's `request` falls. `state_q` moves to ARB_GAP at the next posedge.
- Back-to-back owners are always separated by exactly one grant-free cycle.
- Preemption: the owner holds at most MAX_HOLD cycles. `grant` drops just after the edge at which `hold_q == MAX_HOLD-1` was sampled with competitors pending.
- No combinational path from `request` to `state_q`. The only combinational path from `request` to the outputs is the `grant` / `grant_valid` mask.

## Configuration
- Macro `ARB_ASSERT_EN`.
- When defined, immediate assertions are compiled into the posedge block:
  - `grant` is one-hot-or-zero.
  - `grant & ~request == 0`.
  - `grant_valid` implies `grant[grant_id]`.
  - ARB_GAP implies `grant == 0`.
  - `hold_q < MAX_HOLD` when MAX_HOLD is nonzero.
- Each assertion has a label and `$error` with `$time`. Assertions are disabled while `rst_n` is 0.
- When undefined: no checks. Function and outputs are identical.

## Structure
- Package `arb_pkg`: `typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_BUSY, ARB_GAP}`, plus constants `ARB_MAX_REQ = 16` and `ARB_DEFAULT_HOLD = 8`.
- Sub-module `rr_pick`: purely combinational. Inputs `request` and `last`. Outputs one-hot `winner`, `winner_id` and `any`. One instance, parameterised by NUM_REQ.
- Top: FSM, registers, output masking, optional assertions.

## Test plan
- Reset with `request=4'b0000` → `grant=0`, `grant_valid=0`, `grant_id=0`. Assert `rst_n` mid-grant → `grant` goes to 0 before the next posedge.
- Single requester: `request=4'b0100` from posedge 2 → `grant=4'b0100`, `grant_id=2` from posedge 3. Drop `request` → `grant=0` the same cycle, then ARB_GAP, then ARB_IDLE.
- All four request continuously, each dropping after 2 grant cycles → grant order 0,1,2,3,0 with exactly one zero-grant cycle between owners.
- MAX_HOLD=8, `request=4'b0011` held → owner 0 holds 8 cycles, 1 gap cycle, owner 1 holds 8 cycles, 1 gap cycle, then owner 0 again.
- MAX_HOLD=0, `request=4'b0011` held for 50 cycles → owner 0 keeps the grant for all 50 cycles.
- With `ARB_ASSERT_EN` and downstream checker attached, run 10k cycles of random `request` → zero assertion failures. `grant & ~request` is never nonzero at any posedge.
